// File: rtl/fan_pkg.sv
// Shared definitions for the multi-channel fan PWM generator/supervisor.
// Holds the per-channel state type, its encoding, and the default
// parameter values used by fan_channel and fan_pwm_multi.
package fan_pkg;

  localparam int STATE_W               = 2;
  localparam int DEF_PERIOD_BITWIDTH   = 5;
  localparam int DEF_KICK_PERIODS      = 4;
  localparam int DEF_STALL_PERIODS     = 8;

  // Encoding is visible on state_o and consumed by the status display.
  typedef enum logic [STATE_W-1:0] {
    ST_OFF   = 2'd0,
    ST_KICK  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } fan_state_t;

endpackage

// File: rtl/fan_channel.sv
// One fan channel: shadow/active duty registers, minimum-duty clamp,
// PWM compare, tach synchroniser with rising-edge detect, stall counter
// and the OFF/KICK/RUN/STALL supervisor FSM.
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   run_en_i        high when the period is nonzero; low freezes the channel
//   period_end_i    one-cycle pulse on the last tick of each period
//   counter_i       shared period counter
//   period_i        terminal count of the period counter
//   min_duty_i      minimum nonzero duty in ticks
//   duty_i          new duty word, captured when duty_strb_i is high
//   duty_strb_i     load strobe for duty_i
//   tach_i          asynchronous tach input
//   pwm_o           registered PWM pin
//   stall_o         high while the channel is in STALL
//   state_o         current FSM state
module fan_channel
  import fan_pkg::*;
#(
  parameter int PERIOD_BITWIDTH = DEF_PERIOD_BITWIDTH,
  parameter int KICK_PERIODS    = DEF_KICK_PERIODS,
  parameter int STALL_PERIODS   = DEF_STALL_PERIODS
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       run_en_i,
  input  logic                       period_end_i,
  input  logic [PERIOD_BITWIDTH-1:0] counter_i,
  input  logic [PERIOD_BITWIDTH-1:0] period_i,
  input  logic [PERIOD_BITWIDTH-1:0] min_duty_i,
  input  logic [PERIOD_BITWIDTH-1:0] duty_i,
  input  logic                       duty_strb_i,
  input  logic                       tach_i,
  output logic                       pwm_o,
  output logic                       stall_o,
  output fan_state_t                 state_o
);

  localparam int KW = $clog2(KICK_PERIODS + 1);
  localparam int SW = $clog2(STALL_PERIODS + 1);
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_PERIODS);

  logic [PERIOD_BITWIDTH-1:0] shadow_q, shadow_d;
  logic [PERIOD_BITWIDTH-1:0] active_q, active_d;
  logic [PERIOD_BITWIDTH-1:0] eff;
  logic [2:0]                 tach_q, tach_d;
  logic                       tach_edge;
  logic [SW-1:0]              stall_cnt_q, stall_cnt_d;
  logic [KW-1:0]              kick_cnt_q, kick_cnt_d;
  fan_state_t                 state_q, state_d;
  logic                       pwm_q, pwm_d;
  logic                       raw_pwm;

  // Zero stays zero (fan off); any other request is lifted to the minimum.
  function automatic logic [PERIOD_BITWIDTH-1:0] clamp_duty(
    input logic [PERIOD_BITWIDTH-1:0] act,
    input logic [PERIOD_BITWIDTH-1:0] min_duty
  );
    if (act == '0)
      return '0;
    return (act > min_duty) ? act : min_duty;
  endfunction

  always_comb begin
    // Duty path: a strobe coincident with period_end lands in active directly.
    shadow_d = duty_strb_i ? duty_i : shadow_q;
    active_d = period_end_i ? shadow_d : active_q;
    eff      = clamp_duty(active_q, min_duty_i);
    raw_pwm  = (eff > period_i) || (counter_i < eff);

    // Tach: [0] and [1] are the synchroniser, [2] the previous synced level.
    tach_d    = {tach_q[1], tach_q[0], tach_i};
    tach_edge = run_en_i && tach_q[1] && !tach_q[2];

    // Stall counter: only meaningful in RUN/STALL; a tach edge beats period_end.
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_OFF || state_q == ST_KICK)
      stall_cnt_d = '0;
    else if (tach_edge)
      stall_cnt_d = '0;
    else if (period_end_i && stall_cnt_q != STALL_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;

    // Supervisor FSM; decisions use the duty that becomes active this period_end.
    state_d    = state_q;
    kick_cnt_d = kick_cnt_q;
    case (state_q)
      ST_OFF: begin
        kick_cnt_d = '0;
        if (period_end_i && active_d != '0)
          state_d = ST_KICK;
      end
      ST_KICK: begin
        if (period_end_i) begin
          if (kick_cnt_q == KICK_LAST)
            state_d = ST_RUN;
          else
            kick_cnt_d = kick_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (period_end_i) begin
          if (active_d == '0)
            state_d = ST_OFF;
          else if (stall_cnt_d == STALL_MAX)
            state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (period_end_i && active_d == '0)
          state_d = ST_OFF;
        else if (tach_edge)
          state_d = ST_RUN;
      end
      default: state_d = ST_OFF;
    endcase

    // Pin: driven from the current state and counter, so it lags by one cycle.
    pwm_d = 1'b0;
    if (run_en_i) begin
      case (state_q)
        ST_KICK, ST_STALL: pwm_d = 1'b1;
        ST_RUN:            pwm_d = raw_pwm;
        default:           pwm_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_q    <= '0;
      active_q    <= '0;
      tach_q      <= '0;
      stall_cnt_q <= '0;
      kick_cnt_q  <= '0;
      state_q     <= ST_OFF;
      pwm_q       <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      tach_q      <= tach_d;
      stall_cnt_q <= stall_cnt_d;
      kick_cnt_q  <= kick_cnt_d;
      state_q     <= state_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign stall_o = (state_q == ST_STALL);
  assign state_o = state_q;

endmodule

// File: rtl/fan_pwm_multi.sv
// N-channel fan PWM generator and supervisor. Holds the shared period
// counter and period_end pulse; each channel is an independent fan_channel.
//
// Ports:
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   clk_en_i     counter advance enable
//   period_i     terminal count; period is period_i+1 ticks, 0 stops everything
//   min_duty_i   minimum nonzero duty in ticks
//   duty_i       per-channel duty words, channel k in slice k
//   duty_STRB_i  per-channel duty load strobes
//   tach_i       asynchronous tach inputs
//   PWM_pin_o    registered PWM outputs
//   stall_o      per-channel stall flags
//   state_o      per-channel FSM state, 2 bits each (OFF/KICK/RUN/STALL = 0..3)
module fan_pwm_multi
  import fan_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int PERIOD_BITWIDTH = DEF_PERIOD_BITWIDTH,
  parameter int KICK_PERIODS    = DEF_KICK_PERIODS,
  parameter int STALL_PERIODS   = DEF_STALL_PERIODS
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                clk_en_i,
  input  logic [PERIOD_BITWIDTH-1:0]          period_i,
  input  logic [PERIOD_BITWIDTH-1:0]          min_duty_i,
  input  logic [CHANNELS*PERIOD_BITWIDTH-1:0] duty_i,
  input  logic [CHANNELS-1:0]                 duty_STRB_i,
  input  logic [CHANNELS-1:0]                 tach_i,
  output logic [CHANNELS-1:0]                 PWM_pin_o,
  output logic [CHANNELS-1:0]                 stall_o,
  output logic [2*CHANNELS-1:0]               state_o
);

  logic [PERIOD_BITWIDTH-1:0] counter_q, counter_d;
  logic                       run_en;
  logic                       period_end;

  always_comb begin
    run_en     = (period_i != '0);
    period_end = run_en && clk_en_i && (counter_q == period_i);
    counter_d  = counter_q;
    if (!run_en)
      counter_d = '0;
    // >= also recovers cleanly if period_i shrinks below the current count.
    else if (clk_en_i)
      counter_d = (counter_q >= period_i) ? '0 : counter_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      counter_q <= '0;
    else
      counter_q <= counter_d;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    fan_state_t ch_state;

    fan_channel #(
      .PERIOD_BITWIDTH (PERIOD_BITWIDTH),
      .KICK_PERIODS    (KICK_PERIODS),
      .STALL_PERIODS   (STALL_PERIODS)
    ) u_ch (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .run_en_i     (run_en),
      .period_end_i (period_end),
      .counter_i    (counter_q),
      .period_i     (period_i),
      .min_duty_i   (min_duty_i),
      .duty_i       (duty_i[k*PERIOD_BITWIDTH +: PERIOD_BITWIDTH]),
      .duty_strb_i  (duty_STRB_i[k]),
      .tach_i       (tach_i[k]),
      .pwm_o        (PWM_pin_o[k]),
      .stall_o      (stall_o[k]),
      .state_o      (ch_state)
    );

    assign state_o[2*k +: 2] = ch_state;
  end

endmodule

// File: tb/tb_fan_pwm_multi.sv
// Directed bench for fan_pwm_multi (2 channels, 5-bit period, period_i=19).
// cyc counts rising edges since reset release, so the shared counter equals
// cyc % 20 and period_end updates land on multiples of 20.
module tb_fan_pwm_multi;

  logic       clk_i;
  logic       rstn_i;
  logic       clk_en_i;
  logic [4:0] period_i;
  logic [4:0] min_duty_i;
  logic [9:0] duty_i;
  logic [1:0] duty_STRB_i;
  logic [1:0] tach_i;
  logic [1:0] PWM_pin_o;
  logic [1:0] stall_o;
  logic [3:0] state_o;

  int cyc;
  int checks;
  int errors;
  int hi;
  bit tach_auto;

  fan_pwm_multi #(
    .CHANNELS        (2),
    .PERIOD_BITWIDTH (5),
    .KICK_PERIODS    (4),
    .STALL_PERIODS   (8)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clk_en_i    (clk_en_i),
    .period_i    (period_i),
    .min_duty_i  (min_duty_i),
    .duty_i      (duty_i),
    .duty_STRB_i (duty_STRB_i),
    .tach_i      (tach_i),
    .PWM_pin_o   (PWM_pin_o),
    .stall_o     (stall_o),
    .state_o     (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; sample/drive 1 time unit after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (tach_auto && (cyc % 20 == 10))
        tach_i = ~tach_i;
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c)
      tick(1);
  endtask

  // Count high cycles of channel 0 over n edges, optionally strobing a new
  // ch0 duty when cyc equals strb_at.
  task automatic count_pin0(input int n, input int strb_at, input logic [4:0] v,
                            output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (cyc == strb_at) begin
        duty_i[4:0] = v;
        duty_STRB_i = 2'b01;
      end
      tick(1);
      duty_STRB_i = 2'b00;
      if (PWM_pin_o[0] === 1'b1)
        cnt++;
    end
  endtask

  initial begin
    rstn_i      = 1'b0;
    clk_en_i    = 1'b1;
    period_i    = 5'd19;
    min_duty_i  = 5'd3;
    duty_i      = '0;
    duty_STRB_i = '0;
    tach_i      = '0;
    tach_auto   = 1'b1;
    cyc         = 0;
    checks      = 0;
    errors      = 0;

    tick(3);
    chk("reset_state", 32'(state_o), 32'h0);
    chk("reset_pin",   32'(PWM_pin_o), 32'h0);
    chk("reset_stall", 32'(stall_o), 32'h0);
    cyc    = 0;
    tach_i = '0;
    rstn_i = 1'b1;

    // Start ch0 at duty 10
    duty_i[4:0] = 5'd10;
    duty_STRB_i = 2'b01;
    tick(1);
    duty_STRB_i = 2'b00;
    tick_to(19);
    chk("off_before_pe", 32'(state_o), 32'h0);
    tick_to(20);
    chk("kick_entry", 32'(state_o), 32'h1);
    chk("pin_lag_kick", 32'(PWM_pin_o), 32'h0);
    count_pin0(80, -1, 5'd0, hi);
    chk("kick_high_80", 32'(hi), 32'd80);
    chk("run_entry", 32'(state_o), 32'h2);
    tick_to(110);
    chk("run_pin_last_high", 32'(PWM_pin_o), 32'h1);
    tick(1);
    chk("run_pin_first_low", 32'(PWM_pin_o), 32'h0);
    chk("ch1_state_off", 32'(state_o[3:2]), 32'h0);
    tick_to(120);
    count_pin0(20, -1, 5'd0, hi);
    chk("run_duty10", 32'(hi), 32'd10);

    // Clamp: duty 1 -> min 3, duty 25 -> full
    count_pin0(20, 140, 5'd1, hi);
    chk("old_duty_held", 32'(hi), 32'd10);
    count_pin0(20, -1, 5'd0, hi);
    chk("clamp_min", 32'(hi), 32'd3);
    count_pin0(20, 180, 5'd25, hi);
    chk("clamp_min_again", 32'(hi), 32'd3);
    count_pin0(20, -1, 5'd0, hi);
    chk("clamp_full", 32'(hi), 32'd20);

    // Glitch-free update: 10 active, then 4 strobed at counter=5
    count_pin0(20, 220, 5'd10, hi);
    chk("full_before_10", 32'(hi), 32'd20);
    count_pin0(20, 245, 5'd4, hi);
    chk("glitch_current", 32'(hi), 32'd10);
    count_pin0(20, -1, 5'd0, hi);
    chk("glitch_next", 32'(hi), 32'd4);

    // Stall: tach held low from cyc 280, last edge seen at 253
    tach_auto = 1'b0;
    tach_i    = 2'b00;
    tick_to(399);
    chk("run_before_stall", 32'(state_o), 32'h2);
    chk("no_stall_yet", 32'(stall_o), 32'h0);
    tick(1);
    chk("stall_entry", 32'(state_o), 32'h3);
    chk("stall_flag", 32'(stall_o), 32'h1);
    count_pin0(20, -1, 5'd0, hi);
    chk("stall_full", 32'(hi), 32'd20);
    tick_to(425);
    tach_i = 2'b11;
    tick_to(427);
    chk("stall_before_edge", 32'(state_o), 32'h3);
    tick(1);
    chk("stall_exit", 32'(state_o), 32'h2);
    chk("stall_flag_clear", 32'(stall_o), 32'h0);
    tach_auto = 1'b1;
    tick_to(440);
    count_pin0(20, -1, 5'd0, hi);
    chk("pwm_resumed", 32'(hi), 32'd4);

    // Stop: duty 0
    count_pin0(19, 460, 5'd0, hi);
    chk("run_before_stop", 32'(state_o), 32'h2);
    tick(1);
    chk("stop_off", 32'(state_o), 32'h0);
    count_pin0(20, -1, 5'd0, hi);
    chk("off_pin_low", 32'(hi), 32'd0);

    // Restart, then tach edge coincident with the 8th period_end
    count_pin0(20, 500, 5'd10, hi);
    chk("restart_kick", 32'(state_o), 32'h1);
    tick_to(600);
    chk("restart_run", 32'(state_o), 32'h2);
    tick_to(620);
    tach_auto = 1'b0;
    tach_i    = 2'b00;
    tick_to(757);
    tach_i = 2'b11;
    tick_to(760);
    chk("coincident_no_stall", 32'(state_o), 32'h2);
    chk("coincident_flag", 32'(stall_o), 32'h0);
    tick_to(919);
    chk("run_after_clear", 32'(state_o), 32'h2);
    tick(1);
    chk("stall_after_clear", 32'(state_o), 32'h3);

    // period_i = 0 freezes everything and forces pins low
    tick_to(930);
    period_i = 5'd0;
    tach_i   = 2'b00;
    tick(1);
    chk("period0_pin", 32'(PWM_pin_o), 32'h0);
    tick_to(940);
    tach_i = 2'b11;
    tick_to(980);
    chk("period0_frozen", 32'(state_o), 32'h3);
    chk("period0_pin_held", 32'(PWM_pin_o), 32'h0);
    chk("period0_stall", 32'(stall_o), 32'h1);

    // Asynchronous reset mid-run
    period_i = 5'd19;
    tick(5);
    chk("pre_reset_pin", 32'(PWM_pin_o), 32'h1);
    rstn_i = 1'b0;
    #1;
    chk("async_reset_pin",   32'(PWM_pin_o), 32'h0);
    chk("async_reset_state", 32'(state_o), 32'h0);
    chk("async_reset_stall", 32'(stall_o), 32'h0);
    tick(2);
    chk("reset_held_state", 32'(state_o), 32'h0);
    chk("reset_held_pin",   32'(PWM_pin_o), 32'h0);
    rstn_i = 1'b1;
    tick(40);
    chk("post_reset_off", 32'(state_o), 32'h0);
    chk("post_reset_pin", 32'(PWM_pin_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fan_pwm_multi.md
Name: fan_pwm_multi

Overview:
N-channel fan PWM generator and supervisor, the next generation of the single-fan PWM/PID path. All channels share one period counter. Each channel adds minimum-speed clamping, glitch-free duty updates, kick-start from standstill and tachometer-based stall detection. It sits between the per-channel controller outputs (duty words) and the fan pins; its state_o feeds the status display.

Parameters:
CHANNELS, 2, number of fan channels (>=1)
PERIOD_BITWIDTH, 5, width of the period counter and of the duty words
KICK_PERIODS, 4, full PWM periods forced at 100 % when a channel starts from OFF (>=1)
STALL_PERIODS, 8, PWM periods without a tach rising edge before a channel is declared stalled (>=2)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
clk_en_i  in  1  counter advance enable (time base)
period_i  in  PERIOD_BITWIDTH  terminal count; the period is period_i+1 ticks
min_duty_i  in  PERIOD_BITWIDTH  minimum nonzero duty in ticks
duty_i  in  CHANNELS*PERIOD_BITWIDTH  per-channel duty in ticks; channel k occupies slice k
duty_STRB_i  in  CHANNELS  per-channel load strobe for duty_i
tach_i  in  CHANNELS  asynchronous tach inputs
PWM_pin_o  out  CHANNELS  registered PWM outputs
stall_o  out  CHANNELS  stall flag per channel
state_o  out  2*CHANNELS  per-channel FSM state; encoding OFF=0, KICK=1, RUN=2, STALL=3

Behaviour:
- Reset (async, rstn_i=0) clears every register. PWM_pin_o=0, stall_o=0, state_o=0 (all OFF), counter=0, shadow and active duties=0. Reset takes effect immediately, including mid-KICK or mid-period.
- Counter: advances only when clk_en_i=1. Runs 0..period_i, then wraps to 0. period_end is a one-cycle pulse when counter==period_i and clk_en_i=1.
- period_i==0: counter held at 0, no period_end, all pins forced 0. FSMs and the stall counter freeze.
- Duty load: duty_STRB_i[k] writes slice k into shadow[k]. active[k] is loaded from shadow[k] on period_end. If the strobe and period_end coincide, the new strobe value goes to active.
- Effective duty:
  - eff=0 if active==0.
  - Otherwise eff=max(active, min_duty_i).
  - If eff>period_i, the output is 100 %.
- Compare: raw_pwm = counter < eff. PWM_pin_o is registered, so the pin lags the counter by one cycle.
- Tach: 2-FF synchroniser, then a rising-edge detect, per channel.
- Stall counter (per channel):
  - Increments on each period_end without a tach edge; saturates at STALL_PERIODS.
  - Cleared on a tach edge, on entry to KICK, and in OFF.
  - A tach edge coincident with period_end wins (clear).
- FSM per channel, evaluated on period_end unless noted:
  - OFF: pin 0. If active!=0, go to KICK.
  - KICK: pin 1 for the whole period. After KICK_PERIODS period_ends, go to RUN. Stall detection is not evaluated in KICK.
  - RUN: pin = raw_pwm.
    - active==0 → OFF.
    - stall counter reaches STALL_PERIODS → STALL.
    - Both conditions true: OFF wins.
  - STALL: pin 1 (safety full speed), stall_o=1.
    - A tach edge (any cycle) → RUN, and stall_o clears on the same edge.
    - active==0 at period_end → OFF, stall_o=0.
- The active duty of a channel in KICK or STALL may still change. It is used as soon as the channel reaches RUN.
- Channels are fully independent apart from the shared counter, period_i and min_duty_i.

Decomposition:
- Package fan_pkg holds:
  - the fan_state_t typedef (2-bit OFF/KICK/RUN/STALL);
  - state encoding constants;
  - default PERIOD_BITWIDTH, KICK_PERIODS and STALL_PERIODS localparams.
- Sub-module fan_channel contains one channel's shadow/active duty, clamp, compare, tach synchroniser, stall counter and FSM. It is instantiated CHANNELS times by a generate loop.
- The top level holds only the period counter and period_end generation.

Test Plan:
- Common setup: period_i=19, min_duty_i=3, clk_en_i=1. Tach toggles every 20 cycles unless stated otherwise.
- Reset: assert rstn_i mid-run → PWM_pin_o=0, stall_o=0, state_o=0 in the same cycle, held while rstn_i=0.
- Start and run: ch0 duty=10 strobed → at next period_end state=KICK; pin high 80 cycles (4 periods); then state=RUN with pin high 10 of every 20 cycles. ch1 stays OFF, pin 0.
- Clamp: duty=1 → 3 high ticks per period. duty=25 → pin constantly 1 in RUN.
- Stall: tach held low in RUN → after 8 period_ends stall_o=1, state=3, pin constant 1. A single tach rising edge → stall_o=0, state=2, PWM resumes.
- Glitch-free update: duty 10→4 strobed at counter=5 → current period still 10 high; next period 4 high.
- Stop and edge cases:
  - duty=0 strobed → OFF at next period_end, pin 0.
  - period_i=0 → all pins 0, states frozen.
  - Tach edge coincident with the 8th period_end → no stall.
